// File: rtl/wimpfi_pkg.sv
// wimpfi_pkg: shared types and constants for the wimpfi Manchester link
package wimpfi_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, CRC, EOF} mx_xmit_state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8, MSB-first polynomial, one data bit per enb
module crc8_serial
  import wimpfi_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       enb,
  input  logic       din,
  output logic [7:0] crc
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) crc <= INIT;
    else if (clr) crc <= INIT;
    else if (enb) crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? POLY : 8'h00);
endmodule

// File: rtl/mx_frame_xmit.sv
// mx_frame_xmit: Manchester frame transmitter (preamble, SFD, payload, optional CRC-8, idle-high gap)
module mx_frame_xmit #(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         BIT_RATE     = 50_000,
  parameter int         PREAMBLE_LEN = 2,
  parameter logic [7:0] SFD          = 8'hD0,
  parameter int         EOF_BITS     = 2,
  parameter logic [7:0] CRC_POLY     = 8'h07,
  parameter logic [7:0] CRC_INIT     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  input  logic       crc_append,
  output logic       rdy,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       uerr
);
  import wimpfi_pkg::*;
  localparam int BIT_CYC = CLK_FREQ / BIT_RATE;
  localparam int HALF = BIT_CYC / 2;
  localparam int HW = $clog2(HALF) > 0 ? $clog2(HALF) : 1;
  generate
    if (BIT_CYC % 2 != 0 || BIT_CYC < 4) begin : g_bad_rate
      $fatal(1, "mx_frame_xmit: BIT_CYC must be even and at least 4");
    end
    if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15 || EOF_BITS < 1 || EOF_BITS > 7) begin : g_bad_len
      $fatal(1, "mx_frame_xmit: PREAMBLE_LEN or EOF_BITS out of range");
    end
  endgenerate
  mx_xmit_state_t state, next_state;
  logic [HW-1:0] hcnt;
  logic phase;
  logic [2:0] bit_idx;
  logic [3:0] byte_cnt;
  logic [7:0] shreg, hold, next_byte, crc;
  logic hold_full, hold_last, last_taken, cur_last, crc_on;
  logic half_end, bit_end, byte_end, eof_end, accept, load_hold;
  assign rdy = !hold_full && !last_taken && state != EOF;
  assign busy = state != IDLE;
  assign accept = valid && rdy;
  always_comb begin
    half_end = hcnt == HW'(HALF - 1);
    bit_end = half_end && phase;
    byte_end = bit_end && bit_idx == 3'd7 && state != EOF;
    eof_end = bit_end && bit_idx == 3'(EOF_BITS - 1) && state == EOF;
    next_state = state;
    case (state)
      IDLE: next_state = accept ? PRE : IDLE;
      PRE: if (byte_end && byte_cnt == 4'(PREAMBLE_LEN - 1)) next_state = wimpfi_pkg::SFD;
      wimpfi_pkg::SFD: if (byte_end) next_state = DATA;
      DATA: if (byte_end) next_state = cur_last ? (crc_on ? CRC : EOF) : (hold_full ? DATA : EOF);
      CRC: if (byte_end) next_state = EOF;
      EOF: if (eof_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    load_hold = byte_end && next_state == DATA;
    next_byte = state == PRE ? (byte_cnt == 4'(PREAMBLE_LEN - 1) ? SFD : PREAMBLE_BYTE)
              : (state == DATA && cur_last) ? crc : hold;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      hcnt <= '0;
      phase <= 1'b0;
      bit_idx <= 3'd0;
      byte_cnt <= 4'd0;
      shreg <= 8'h00;
      hold <= 8'h00;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      last_taken <= 1'b0;
      cur_last <= 1'b0;
      crc_on <= 1'b0;
      txd <= 1'b1;
      done <= 1'b0;
      uerr <= 1'b0;
    end else begin
      state <= next_state;
      done <= eof_end;
      uerr <= state == DATA && byte_end && !cur_last && !hold_full;
      if (accept) begin
        hold <= data;
        hold_last <= last;
      end
      // a byte caught on an underrun boundary is dropped when the frame closes
      hold_full <= eof_end ? 1'b0 : accept ? 1'b1 : load_hold ? 1'b0 : hold_full;
      last_taken <= eof_end ? 1'b0 : (accept && last) ? 1'b1 : last_taken;
      if (load_hold) cur_last <= hold_last;
      if (state == IDLE) begin
        txd <= accept ? PREAMBLE_BYTE[0] : 1'b1;
        hcnt <= '0;
        phase <= 1'b0;
        bit_idx <= 3'd0;
        byte_cnt <= 4'd0;
        shreg <= PREAMBLE_BYTE;
        if (accept) crc_on <= crc_append;
      end else begin
        hcnt <= half_end ? '0 : hcnt + 1'b1;
        if (half_end) phase <= !phase;
        if (half_end && !phase) txd <= state == EOF || !shreg[0];
        if (bit_end) begin
          bit_idx <= (byte_end || eof_end) ? 3'd0 : bit_idx + 3'd1;
          shreg <= byte_end ? next_byte : shreg >> 1;
          txd <= byte_end ? (next_state == EOF || next_byte[0]) : (state == EOF || shreg[1]);
          if (byte_end) byte_cnt <= next_state == state ? byte_cnt + 4'd1 : 4'd0;
        end
      end
    end
  // CRC advances mid-bit so the final value is settled by the byte boundary
  crc8_serial #(.POLY(CRC_POLY), .INIT(CRC_INIT)) u_crc (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && accept),
    .enb(state == DATA && half_end && !phase),
    .din(shreg[0]),
    .crc(crc)
  );
endmodule

// File: tb/tb_mx_frame_xmit.sv
// tb_mx_frame_xmit: directed frames decoded from txd and compared with hand-computed bytes and lengths
module tb_mx_frame_xmit;
  localparam int BC = 8;
  logic clk = 1'b0, rst = 1'b0, valid = 1'b0, last = 1'b0, crc_append = 1'b0;
  logic [7:0] data = 8'h00;
  logic rdy, txd, busy, done, uerr;
  int checks = 0, errors = 0;
  mx_frame_xmit #(.CLK_FREQ(8), .BIT_RATE(1), .PREAMBLE_LEN(2), .SFD(8'hD0), .EOF_BITS(2),
                  .CRC_POLY(8'h07), .CRC_INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .last(last), .crc_append(crc_append),
    .rdy(rdy), .txd(txd), .busy(busy), .done(done), .uerr(uerr));
  always #5 clk = ~clk;
  logic [7:0] rx[$], f_rx[$], exp_q[$];
  logic [7:0] sh;
  logic a_s;
  int k, nb, eof_cyc, idle_n, gap, frames = 0, done_cnt = 0;
  int uerr_n, uerr_at, f_len, f_eof, f_uerr_n, f_uerr_at;
  bit in_eof, bad, rdy_eof, was_busy = 0, f_bad, f_done, f_rdy_eof;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) begin
      if (!was_busy) begin
        gap = idle_n;
        k = 0; nb = 0; rx.delete(); in_eof = 0; eof_cyc = 0; bad = 0; rdy_eof = 0; uerr_n = 0; uerr_at = -1;
      end
      if (uerr) begin uerr_n++; uerr_at = k; end
      if (in_eof) begin
        eof_cyc++;
        if (txd !== 1'b1) bad = 1;
        if (rdy) rdy_eof = 1;
      end else if (k % BC == 1) a_s = txd;
      else if (k % BC == 5) begin
        if (txd === ~a_s) begin
          sh = {a_s, sh[7:1]};
          nb++;
          if (nb == 8) begin rx.push_back(sh); nb = 0; end
        end else if (a_s === 1'b1 && txd === 1'b1 && nb == 0) begin
          in_eof = 1; eof_cyc = 6;
        end else bad = 1;
      end
      k++;
    end else begin
      if (was_busy) begin
        f_rx = rx; f_len = k; f_eof = eof_cyc; f_bad = bad; f_done = done; f_rdy_eof = rdy_eof;
        f_uerr_n = uerr_n; f_uerr_at = uerr_at; frames++; idle_n = 0;
      end
      idle_n++;
    end
    was_busy = busy;
  end
  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l, input logic c);
    int t = 0;
    data = d; last = l; crc_append = c; valid = 1'b1;
    while (!rdy && t < 2000) begin @(negedge clk); t++; end
    chk("send_timeout", 32'(t < 2000), 1);
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 2000) begin @(negedge clk); t++; end
    chk("frame_timeout", 32'(frames >= n), 1);
    @(negedge clk);
  endtask
  task automatic chk_frame(input string tag, input int len);
    chk({tag, "_nbytes"}, f_rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < f_rx.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), f_rx[i], exp_q[i]);
    chk({tag, "_len"}, f_len, len);
    chk({tag, "_eof_cycles"}, f_eof, 2 * BC);
    chk({tag, "_line_ok"}, f_bad, 0);
    chk({tag, "_done_at_end"}, f_done, 1);
  endtask
  initial begin
    int d0;
    logic [7:0] c;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1); chk("rst_rdy", rdy, 1); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_uerr", uerr, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_rst_txd", txd, 1); chk("idle_rst_rdy", rdy, 1); chk("idle_rst_busy", busy, 0);
    chk("idle_rst_done", done, 0); chk("idle_rst_uerr", uerr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    send(8'h4F, 0, 0); send(8'h5A, 0, 0); send(8'h30, 0, 0); send(8'hAA, 1, 0);
    wait_frames(1);
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'h4F, 8'h5A, 8'h30, 8'hAA};
    chk_frame("plain", 464);
    chk("plain_done_once", done_cnt - d0, 1);
    chk("plain_no_uerr", f_uerr_n, 0);
    chk("plain_idle_txd", txd, 1);
    c = crc_byte(crc_byte(crc_byte(8'h00, 8'h4F), 8'h5A), 8'h31);
    send(8'h4F, 0, 1); send(8'h5A, 0, 1); send(8'h31, 1, 1);
    wait_frames(2);
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'h4F, 8'h5A, 8'h31, c};
    chk_frame("crc", 464);
    if (f_rx.size() == 7)
      chk("crc_rx_check", crc_byte(crc_byte(crc_byte(8'h00, f_rx[3]), f_rx[4]), f_rx[5]), f_rx[6]);
    send(8'h4F, 0, 1); send(8'h5A, 0, 0);
    wait_frames(3);
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'h4F, 8'h5A};
    chk_frame("underrun", 336);
    chk("underrun_uerr_count", f_uerr_n, 1);
    chk("underrun_uerr_cycle", f_uerr_at, 320);
    chk("underrun_idle_rdy", rdy, 1);
    send(8'h11, 0, 0); send(8'h22, 1, 0); send(8'h33, 0, 0);
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'h11, 8'h22};
    chk_frame("b2b_first", 336);
    chk("b2b_rdy_low_in_eof", f_rdy_eof, 0);
    send(8'h44, 1, 0);
    wait_frames(5);
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'h33, 8'h44};
    chk_frame("b2b_second", 336);
    chk("b2b_gap", gap, 1);
    send(8'h4F, 0, 0); send(8'h5A, 0, 0);
    repeat (40) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_txd", txd, 1); chk("async_rst_busy", busy, 0); chk("async_rst_rdy", rdy, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    d0 = frames;
    send(8'h2A, 0, 0); send(8'h5A, 0, 0); send(8'h30, 1, 0);
    wait_frames(d0 + 1);
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'h2A, 8'h5A, 8'h30};
    chk_frame("post_reset", 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
